// File: rtl/conv2d_pkg.sv
// Shared types and sizing helpers for the line-buffered 2D convolution engine.
package conv2d_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWtReq,
    StWtResp,
    StRowReq,
    StRowResp,
    StMac,
    StWrReq,
    StDone
  } state_e;

  function automatic int unsigned halo(input int unsigned wt_dim);
    return (wt_dim - 1) / 2;
  endfunction

  function automatic int unsigned word_bytes(input int unsigned dwidth);
    return dwidth / 8;
  endfunction

  // Wide enough to hold MAX_FM_DIM itself, not just MAX_FM_DIM-1.
  function automatic int unsigned cnt_width(input int unsigned max_dim);
    return $clog2(max_dim) + 1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv2d_line_buffer.sv
// Circular WT_DIM-row line buffer; reads outside the N x N map return zero (padding).
module conv2d_line_buffer #(
  parameter int unsigned WT_DIM     = 3,
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned MAX_FM_DIM = 64,
  parameter int unsigned CW         = 7,
  parameter int unsigned SW         = 2,
  parameter int unsigned ColW       = 6
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [SW-1:0]        wr_slot_i,
  input  logic [ColW-1:0]      wr_col_i,
  input  logic [DWIDTH-1:0]    wr_data_i,
  input  logic [CW-1:0]        n_i,
  input  logic signed [CW:0]   rd_row_i,
  input  logic signed [CW:0]   rd_col_i,
  output logic [DWIDTH-1:0]    rd_data_o
);

  logic [DWIDTH-1:0] mem_q [WT_DIM][MAX_FM_DIM];
  logic signed [CW:0] n_s;
  logic [SW-1:0]      rd_slot;
  logic               in_range;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_slot_i][wr_col_i] <= wr_data_i;
    end
  end

  always_comb begin
    n_s      = $signed({1'b0, n_i});
    in_range = !rd_row_i[CW] && !rd_col_i[CW] && (rd_row_i < n_s) && (rd_col_i < n_s);
    rd_slot  = SW'(32'(rd_row_i[CW-1:0]) % WT_DIM);
    rd_data_o = in_range ? mem_q[rd_slot][rd_col_i[ColW-1:0]] : '0;
  end

endmodule

// File: rtl/conv2d_linebuf.sv
// 2D convolution engine: weights in a register file, each IFM word fetched once into a
// circular line buffer, one MAC per cycle, results written back over a single memory port.
module conv2d_linebuf
  import conv2d_pkg::*;
#(
  parameter int unsigned WT_DIM     = 3,
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned MAX_FM_DIM = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              idle,
  output logic              done,
  input  logic [31:0]       fm_dim,
  input  logic [31:0]       wt_offset,
  input  logic [31:0]       ifm_offset,
  input  logic [31:0]       ofm_offset,
  input  logic              relu_en,
  output logic [31:0]       mem_req_addr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [DWIDTH-1:0] mem_req_data,
  output logic              mem_req_write,
  input  logic [DWIDTH-1:0] mem_resp_data,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready
);

  localparam int unsigned H      = halo(WT_DIM);
  localparam int unsigned CW     = cnt_width(MAX_FM_DIM);
  localparam int unsigned RW     = CW + 1;
  localparam int unsigned NumWt  = WT_DIM * WT_DIM;
  localparam int unsigned KW     = idx_width(NumWt);
  localparam int unsigned SW     = idx_width(WT_DIM);
  localparam int unsigned ColW   = idx_width(MAX_FM_DIM);
  localparam int unsigned Stride = word_bytes(DWIDTH);

  state_e            state_q, state_d;
  logic [CW-1:0]     n_q, n_d, next_row_q, next_row_d, col_q, col_d;
  logic [CW-1:0]     y_q, y_d, x_q, x_d;
  logic [31:0]       wt_off_q, wt_off_d, ifm_off_q, ifm_off_d, ofm_off_q, ofm_off_d;
  logic              relu_q, relu_d, done_q, done_d;
  logic [KW-1:0]     k_q, k_d;
  logic [SW-1:0]     ki_q, ki_d, kj_q, kj_d;
  logic [DWIDTH-1:0] acc_q, acc_d, result;
  logic [DWIDTH-1:0] wt_q [NumWt];
  logic signed [RW-1:0] lb_rd_row, lb_rd_col;
  logic [DWIDTH-1:0] lb_rd_data;
  logic              lb_we, enter_pixel;

  // A row must be resident before output row y uses it: rows up to y+H, clipped to N-1.
  function automatic logic need_row(input logic [CW-1:0] nr, input logic [CW-1:0] row,
                                    input logic [CW-1:0] n);
    return (int'(nr) <= int'(row) + int'(H)) && (nr < n);
  endfunction

  assign lb_we  = (state_q == StRowResp) && mem_resp_valid;
  assign result = (relu_q && acc_q[DWIDTH-1]) ? '0 : acc_q;

  always_comb begin
    lb_rd_row = RW'(int'(y_q) + int'(ki_q) - int'(H));
    lb_rd_col = RW'(int'(x_q) + int'(kj_q) - int'(H));
  end

  conv2d_line_buffer #(
    .WT_DIM    (WT_DIM),
    .DWIDTH    (DWIDTH),
    .MAX_FM_DIM(MAX_FM_DIM),
    .CW        (CW),
    .SW        (SW),
    .ColW      (ColW)
  ) u_line_buffer (
    .clk_i    (clk),
    .wr_en_i  (lb_we),
    .wr_slot_i(SW'(32'(next_row_q) % WT_DIM)),
    .wr_col_i (col_q[ColW-1:0]),
    .wr_data_i(mem_resp_data),
    .n_i      (n_q),
    .rd_row_i (lb_rd_row),
    .rd_col_i (lb_rd_col),
    .rd_data_o(lb_rd_data)
  );

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    next_row_d  = next_row_q;
    col_d       = col_q;
    y_d         = y_q;
    x_d         = x_q;
    wt_off_d    = wt_off_q;
    ifm_off_d   = ifm_off_q;
    ofm_off_d   = ofm_off_q;
    relu_d      = relu_q;
    done_d      = done_q;
    k_d         = k_q;
    ki_d        = ki_q;
    kj_d        = kj_q;
    acc_d       = acc_q;
    enter_pixel = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          n_d       = fm_dim[CW-1:0];
          wt_off_d  = wt_offset;
          ifm_off_d = ifm_offset;
          ofm_off_d = ofm_offset;
          relu_d    = relu_en;
          k_d       = '0;
          if (fm_dim == 32'd0 || fm_dim > 32'(MAX_FM_DIM)) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StWtReq;
            done_d  = 1'b0;
          end
        end
      end
      StWtReq: if (mem_req_ready) state_d = StWtResp;
      StWtResp: begin
        if (mem_resp_valid) begin
          if (k_q == KW'(NumWt - 1)) begin
            next_row_d = '0;
            col_d      = '0;
            y_d        = '0;
            x_d        = '0;
            state_d    = StRowReq;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = StWtReq;
          end
        end
      end
      StRowReq: if (mem_req_ready) state_d = StRowResp;
      StRowResp: begin
        if (mem_resp_valid) begin
          if (col_q == n_q - CW'(1)) begin
            col_d      = '0;
            next_row_d = next_row_q + CW'(1);
            if (need_row(next_row_q + CW'(1), y_q, n_q)) state_d = StRowReq;
            else enter_pixel = 1'b1;
          end else begin
            col_d   = col_q + CW'(1);
            state_d = StRowReq;
          end
        end
      end
      StMac: begin
        acc_d = acc_q + wt_q[k_q] * lb_rd_data;
        k_d   = k_q + KW'(1);
        if (kj_q == SW'(WT_DIM - 1)) begin
          kj_d = '0;
          if (ki_q == SW'(WT_DIM - 1)) state_d = StWrReq;
          else ki_d = ki_q + SW'(1);
        end else begin
          kj_d = kj_q + SW'(1);
        end
      end
      StWrReq: begin
        if (mem_req_ready) begin
          if (x_q == n_q - CW'(1)) begin
            x_d = '0;
            if (y_q == n_q - CW'(1)) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              y_d = y_q + CW'(1);
              if (need_row(next_row_q, y_q + CW'(1), n_q)) state_d = StRowReq;
              else enter_pixel = 1'b1;
            end
          end else begin
            x_d         = x_q + CW'(1);
            enter_pixel = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter_pixel) begin
      state_d = StMac;
      k_d     = '0;
      ki_d    = '0;
      kj_d    = '0;
      acc_d   = '0;
    end
  end

  always_comb begin
    mem_req_addr   = '0;
    mem_req_data   = '0;
    mem_req_valid  = 1'b0;
    mem_req_write  = 1'b0;
    mem_resp_ready = 1'b0;
    unique case (state_q)
      StWtReq: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = wt_off_q + 32'(k_q) * Stride;
      end
      StRowReq: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = ifm_off_q + (32'(next_row_q) * 32'(n_q) + 32'(col_q)) * Stride;
      end
      StWrReq: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_data  = result;
        mem_req_addr  = ofm_off_q + (32'(y_q) * 32'(n_q) + 32'(x_q)) * Stride;
      end
      StWtResp, StRowResp: mem_resp_ready = 1'b1;
      default: ;
    endcase
  end

  assign idle = (state_q == StIdle) || (state_q == StDone);
  assign done = done_q;

  always_ff @(posedge clk) begin
    if (state_q == StWtResp && mem_resp_valid) begin
      wt_q[k_q] <= mem_resp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      n_q        <= '0;
      next_row_q <= '0;
      col_q      <= '0;
      y_q        <= '0;
      x_q        <= '0;
      wt_off_q   <= '0;
      ifm_off_q  <= '0;
      ofm_off_q  <= '0;
      relu_q     <= 1'b0;
      done_q     <= 1'b0;
      k_q        <= '0;
      ki_q       <= '0;
      kj_q       <= '0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      next_row_q <= next_row_d;
      col_q      <= col_d;
      y_q        <= y_d;
      x_q        <= x_d;
      wt_off_q   <= wt_off_d;
      ifm_off_q  <= ifm_off_d;
      ofm_off_q  <= ofm_off_d;
      relu_q     <= relu_d;
      done_q     <= done_d;
      k_q        <= k_d;
      ki_q       <= ki_d;
      kj_q       <= kj_d;
      acc_q      <= acc_d;
    end
  end

endmodule

// File: doc/conv2d_linebuf.md
Name: conv2D_linebuf

Overview:
Next-generation 2D convolution accelerator. It keeps the start/idle/done control interface and the single memory request/response port of the existing naive engine. Weights are loaded once into a register file, and each IFM element is read exactly once into a WT_DIM-row circular line buffer. Each output pixel is then computed from on-chip storage, with optional ReLU. The block sits between the CPU-visible accelerator control registers and the memory arbiter.

Parameters:
WT_DIM, 3, kernel side length; must be odd and >= 1; halo H = (WT_DIM-1)/2
DWIDTH, 32, data word width in bits; byte stride per word = DWIDTH/8
MAX_FM_DIM, 64, maximum feature-map side; sets line-buffer depth and counter widths

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a job when idle
idle  out  1  high when no job is in progress
done  out  1  high from job completion until the next accepted start or rst
fm_dim  in  32  feature-map side N; sampled on the accepted start
wt_offset  in  32  byte base address of WT_DIM*WT_DIM weights, row-major
ifm_offset  in  32  byte base address of the N*N input map, row-major
ofm_offset  in  32  byte base address of the N*N output map, row-major
relu_en  in  1  sampled on start; when set, negative results are written as 0
mem_req_addr  out  32  byte address
mem_req_valid  out  1  request valid
mem_req_ready  in  1  request accepted when valid & ready
mem_req_data  out  DWIDTH  write data
mem_req_write  out  1  1 = write, 0 = read
mem_resp_data  in  DWIDTH  read data
mem_resp_valid  in  1  read response valid
mem_resp_ready  out  1  high only while waiting for a read response

Behaviour:
- Reset values: idle=1, done=0, mem_req_valid=0, mem_resp_ready=0, mem_req_write=0, addr/data=0. All counters and the FSM go to IDLE. rst mid-job aborts immediately; no further requests are issued.
- Function: ofm[y][x] = sum over i,j of wt[i][j] * ifm[y+i-H][x+j-H]. Out-of-range ifm elements read as 0 (same-size output, zero padding).
- Arithmetic: signed two's complement; products and sum are truncated to DWIDTH bits (wrap). ReLU tests the MSB of the final sum.
- Start handling: start is ignored unless the FSM is in IDLE or DONE. An accepted start clears done and latches fm_dim, the three offsets and relu_en.
- Degenerate sizes: fm_dim==0 or fm_dim>MAX_FM_DIM makes the FSM go IDLE -> DONE in 1 cycle with no memory traffic.
- FSM states: IDLE, WT_REQ, WT_RESP, ROW_REQ, ROW_RESP, MAC, WR_REQ, DONE.
- WT_REQ/WT_RESP: load WT_DIM^2 weights, one outstanding read at a time; addr = wt_offset + k*DWIDTH/8.
- Row loading: a next_row counter starts at 0. Before computing output row y, the FSM loads whole rows while next_row <= y+H and next_row < N. Each element goes to line-buffer slot next_row mod WT_DIM; addr = ifm_offset + (r*N+c)*DWIDTH/8.
- MAC: one product per cycle, so WT_DIM^2 cycles per pixel. The accumulator clears at the start of each pixel.
- WR_REQ: writes one word; addr = ofm_offset + (y*N+x)*DWIDTH/8. A write completes on the req handshake; writes get no response.
- Pixel sequencing: after WR_REQ, go to the next x. At x==N-1 go to the next y, through the row-loading check. After the last pixel go to DONE.
- Request handshake: once valid is raised, addr, data and write are held stable until ready. Valid never drops without a handshake. mem_req_valid is low in the *_RESP and MAC states.
- Response handshake: a response is consumed only when mem_resp_valid & mem_resp_ready.
- idle = state is IDLE or DONE.
- Traffic totals: exactly WT_DIM^2 + N^2 reads and N^2 writes per job.

Decomposition:
- Shared package conv2D_pkg:
  - FSM state enum.
  - Function computing H from WT_DIM.
  - Word byte-stride constant.
  - Counter width constant $clog2(MAX_FM_DIM)+1.
- Sub-module conv2D_line_buffer:
  - WT_DIM x MAX_FM_DIM storage.
  - Write port: row slot and column.
  - Read port: logical row and column. Returns 0 when the row or column is outside 0..N-1, so all padding logic lives here.

Test Plan:
- N=4, centre-only kernel (wt[1][1]=1, rest 0), ifm=0..15 -> ofm equals ifm; 25 reads, 16 writes; done rises, idle=1.
- N=4, all-ones kernel, all-ones ifm -> corners 4, edge pixels 6, interior 9.
- N=3, all-ones kernel, ifm=-1 everywhere, relu_en=1 -> all ofm=0; same job with relu_en=0 -> corners -4, centre -9.
- N=5 with mem_req_ready randomly low 50% and response delay 0-5 cycles -> results identical to the zero-wait run; request fields stable while stalled.
- fm_dim=0 and fm_dim=MAX_FM_DIM+1 -> done one cycle after start; mem_req_valid never asserted.
- rst asserted mid-MAC during N=4 job -> next cycle idle=1, done=0, valid=0; a fresh start then completes correctly; a start pulsed while busy is ignored.
